// File: rtl/lzc_norm_pipe.sv
// Two-stage leading/trailing-zero counter and normaliser with valid/ready flow control.
// S1 captures the beat plus its zero count; S2 produces the count, zero flag and shifted value.
module lzc_norm_pipe #(
    parameter  int WIDTH = 16,
    parameter  int TAG_W = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_mode,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LVL = $clog2(WIDTH);
    localparam int PW  = 1 << LVL;

    // Valid/position tree over a power-of-two vector; each node prefers its upper half,
    // otherwise takes the lower half's position with the new MSB set.
    function automatic logic [CNT_W-1:0] lzc(input logic [PW-1:0] pad);
        logic [LVL:0][PW-1:0]          tv;
        logic [LVL:0][PW-1:0][LVL-1:0] tp;
        tv    = '0;
        tp    = '0;
        tv[0] = pad;
        for (int l = 1; l <= LVL; l++) begin
            for (int n = 0; n < (PW >> l); n++) begin
                tv[l][n] = tv[l-1][2*n+1] | tv[l-1][2*n];
                tp[l][n] = tv[l-1][2*n+1] ? tp[l-1][2*n+1]
                                          : (tp[l-1][2*n] | LVL'(1 << (l - 1)));
            end
        end
        return tv[LVL][0] ? {1'b0, tp[LVL][0]} : CNT_W'(WIDTH);
    endfunction

    logic [WIDTH-1:0] src;
    logic [PW-1:0]    pad;
    logic [CNT_W-1:0] cnt_d;

    // Trailing mode reuses the leading-zero tree on the bit-reversed word; padding sits
    // below the data so it can only matter when the word is all zeros.
    always_comb begin
        src = in_data;
        if (in_mode) begin
            for (int i = 0; i < WIDTH; i++) src[i] = in_data[WIDTH-1-i];
        end
        pad = '0;
        pad[PW-1 -: WIDTH] = src;
        cnt_d = lzc(pad);
    end

    logic [2:1]       vld_pipe;
    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] s1_data;
    logic             s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [CNT_W-1:0] s1_cnt;
    logic [WIDTH-1:0] norm_d;

    assign s2_adv   = ~vld_pipe[2] | out_ready;
    assign s1_adv   = ~vld_pipe[1] | s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = vld_pipe[2];

    // A count of WIDTH shifts everything out, so the all-zero case needs no special path.
    assign norm_d = s1_mode ? (s1_data >> s1_cnt) : (s1_data << s1_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            s1_data   <= '0;
            s1_mode   <= 1'b0;
            s1_tag    <= '0;
            s1_cnt    <= '0;
            out_count <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
            out_mode  <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (s1_adv) vld_pipe[1] <= in_valid;
            if (s2_adv) vld_pipe[2] <= vld_pipe[1];
            if (in_valid && s1_adv) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
                s1_tag  <= in_tag;
                s1_cnt  <= cnt_d;
            end
            if (vld_pipe[1] && s2_adv) begin
                out_count <= s1_cnt;
                out_zero  <= (s1_cnt == CNT_W'(WIDTH));
                out_norm  <= norm_d;
                out_mode  <= s1_mode;
                out_tag   <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: directed literal checks on a 16-bit instance plus an
// exhaustive 11-bit sweep, both scored against a bit-scanning reference model.
module tb_lzc_norm_pipe;
    logic clk, rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int cnt;
        bit zero;
        int norm;
        int tag;
        bit mode;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    // 16-bit instance
    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
    logic        a_out_zero, a_out_mode;
    logic [15:0] a_in_data, a_out_norm;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [4:0]  a_out_count;

    // 11-bit instance
    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
    logic        b_out_zero, b_out_mode;
    logic [10:0] b_in_data, b_out_norm;
    logic [1:0]  b_in_tag, b_out_tag;
    logic [4:0]  b_out_count;

    lzc_norm_pipe #(.WIDTH(16), .TAG_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
        .out_zero(a_out_zero), .out_norm(a_out_norm), .out_mode(a_out_mode),
        .out_tag(a_out_tag)
    );

    lzc_norm_pipe #(.WIDTH(11), .TAG_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
        .out_zero(b_out_zero), .out_norm(b_out_norm), .out_mode(b_out_mode),
        .out_tag(b_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) b_out_ready <= 1'($urandom_range(0, 1));

    // Reference: scan from the chosen end until the first set bit.
    function automatic int ref_cnt(input int d, input bit m, input int w);
        for (int i = 0; i < w; i++) begin
            int b;
            b = m ? i : (w - 1 - i);
            if (((d >> b) & 1) == 1) return i;
        end
        return w;
    endfunction

    function automatic int ref_norm(input int d, input bit m, input int w);
        int c;
        c = ref_cnt(d, m, w);
        if (c >= w) return 0;
        return m ? (d >> c) : ((d << c) & ((1 << w) - 1));
    endfunction

    function automatic exp_t mk(input int d, input bit m, input int t, input int w);
        exp_t e;
        e.cnt  = ref_cnt(d, m, w);
        e.zero = (e.cnt == w);
        e.norm = ref_norm(d, m, w);
        e.tag  = t;
        e.mode = m;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle an output is presented it must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid) begin
                if (qa.size() == 0) chk("a_unexpected_valid", int'(a_out_valid), 0);
                else begin
                    ea = qa[0];
                    chk("a_count", int'(a_out_count), ea.cnt);
                    chk("a_zero", int'(a_out_zero), int'(ea.zero));
                    chk("a_norm", int'(a_out_norm), ea.norm);
                    chk("a_tag", int'(a_out_tag), ea.tag);
                    chk("a_mode", int'(a_out_mode), int'(ea.mode));
                    if (a_out_ready) qa.delete(0);
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(mk(int'(a_in_data), a_in_mode, int'(a_in_tag), 16));
            if (b_out_valid) begin
                if (qb.size() == 0) chk("b_unexpected_valid", int'(b_out_valid), 0);
                else begin
                    eb = qb[0];
                    chk("b_count", int'(b_out_count), eb.cnt);
                    chk("b_zero", int'(b_out_zero), int'(eb.zero));
                    chk("b_norm", int'(b_out_norm), eb.norm);
                    chk("b_tag", int'(b_out_tag), eb.tag);
                    chk("b_mode", int'(b_out_mode), int'(eb.mode));
                    if (b_out_ready) qb.delete(0);
                end
            end
            if (b_in_valid && b_in_ready) qb.push_back(mk(int'(b_in_data), b_in_mode, int'(b_in_tag), 11));
        end
    end

    task automatic send_a(input int d, input bit m, input int t);
        int n;
        n = 0;
        a_in_data  = d[15:0];
        a_in_mode  = m;
        a_in_tag   = t[3:0];
        a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_ready) chk("a_send_timeout", int'(a_in_ready), 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input int d, input bit m);
        int n;
        n = 0;
        b_in_data  = d[10:0];
        b_in_mode  = m;
        b_in_tag   = d[1:0];
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) chk("b_send_timeout", int'(b_in_ready), 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic exp_a(input string nm, input int cnt, input bit z, input int norm, input int tag);
        chk({nm, "_valid"}, int'(a_out_valid), 1);
        chk({nm, "_count"}, int'(a_out_count), cnt);
        chk({nm, "_zero"}, int'(a_out_zero), int'(z));
        chk({nm, "_norm"}, int'(a_out_norm), norm);
        chk({nm, "_tag"}, int'(a_out_tag), tag);
    endtask

    task automatic idle_a(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int mix [8];
        int n;
        mix = '{'h0001, 'h0140, 'h8000, 'h8000, 'h00f0, 'h0000, 'h0003, 'hc000};
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_tag = '0;

        // model pins
        chk("pin_lz_0001", ref_cnt('h0001, 0, 16), 15);
        chk("pin_tz_0140", ref_cnt('h0140, 1, 16), 6);
        chk("pin_tnorm_0140", ref_norm('h0140, 1, 16), 'h0005);
        chk("pin_lnorm_00f0", ref_norm('h00f0, 0, 16), 'hf000);
        chk("pin_zero_w11", ref_cnt(0, 1, 11), 11);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_in_ready", int'(a_in_ready), 1);
        chk("rst_count", int'(a_out_count), 0);
        chk("rst_norm", int'(a_out_norm), 0);
        rst_n = 1'b1;
        idle_a(1);
        chk("post_rst_in_ready", int'(a_in_ready), 1);

        // leading mode, streamed back-to-back
        send_a('h0001, 0, 1);
        send_a('h8000, 0, 2);
        exp_a("lz_0001", 15, 0, 'h8000, 1);
        send_a('h00f0, 0, 3);
        exp_a("lz_8000", 0, 0, 'h8000, 2);
        idle_a(1);
        exp_a("lz_00f0", 8, 0, 'hf000, 3);
        idle_a(2);

        // all zeros in both modes
        send_a('h0000, 0, 5);
        send_a('h0000, 1, 6);
        exp_a("zero_m0", 16, 1, 0, 5);
        idle_a(1);
        exp_a("zero_m1", 16, 1, 0, 6);
        idle_a(2);

        // trailing mode
        send_a('h0140, 1, 7);
        send_a('h8000, 1, 8);
        exp_a("tz_0140", 6, 0, 'h0005, 7);
        idle_a(1);
        exp_a("tz_8000", 15, 0, 'h0001, 8);
        idle_a(2);

        // interleaved modes, model-checked
        for (int i = 0; i < 8; i++) send_a(mix[i], i[0], i + 4);
        idle_a(4);

        // backpressure: only two beats fit
        a_out_ready = 1'b0;
        a_in_data = 16'h0100; a_in_mode = 1'b0; a_in_tag = 4'd1; a_in_valid = 1'b1;
        @(posedge clk); #1; a_in_tag = 4'd2;
        @(posedge clk); #1; a_in_tag = 4'd3;
        chk("bp_full_in_ready", int'(a_in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_stall_in_ready", int'(a_in_ready), 0);
            exp_a("bp_hold_t1", 7, 0, 'h8000, 1);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        exp_a("bp_t2", 7, 0, 'h8000, 2);
        @(posedge clk); #1;
        exp_a("bp_t3", 7, 0, 'h8000, 3);
        @(posedge clk); #1;
        chk("bp_drained", int'(a_out_valid), 0);

        // reset with two beats in flight
        send_a('h1234, 0, 10);
        send_a('h0001, 1, 11);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(a_out_valid), 0);
        chk("rst_mid_count", int'(a_out_count), 0);
        chk("rst_mid_zero", int'(a_out_zero), 0);
        chk("rst_mid_norm", int'(a_out_norm), 0);
        chk("rst_mid_tag", int'(a_out_tag), 0);
        chk("rst_mid_in_ready", int'(a_in_ready), 1);
        idle_a(2);
        rst_n = 1'b1;
        idle_a(1);
        send_a('h0010, 0, 9);
        idle_a(1);
        exp_a("rst_new_beat", 11, 0, 'h8000, 9);
        idle_a(1);
        chk("rst_no_stale", int'(a_out_valid), 0);
        idle_a(2);
        chk("rst_no_stale_late", int'(a_out_valid), 0);

        // exhaustive 11-bit sweep with random downstream stalls
        for (int m = 0; m < 2; m++)
            for (int d = 0; d < 2048; d++) send_b(d, m[0]);
        n = 0;
        while ((qb.size() != 0 || b_out_valid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("b_drain", qb.size(), 0);
        chk("a_drain", qa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
